// File: rtl/ifetch_sequencer.sv
// Instruction fetch sequencer: fetches the word at pc_in over a req/ack imem port,
// holds it for decode and steps the PC. Build with IFETCH_BNE_EN to also branch on BNE.
module ifetch_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [5:0]  BEQ_OPCODE     = 6'b000100,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_in,
  input  logic             zero,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic             pc_step,
  output logic             nPC_sel,
  output logic [15:0]      imm16,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [5:0]  BNE_OPCODE = 6'b000101;

  typedef enum logic [1:0] {REQ, WAIT, ISSUE, SETTLE} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             req_q, req_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             step_q, step_d;
  logic             nsel_q, nsel_d;
  logic [15:0]      imm_q, imm_d;
  logic             err_q, err_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             branch_c;

  // Branch decision for the held word, using zero as seen in the transfer cycle
  always_comb begin
    branch_c = (instr_q[31:26] == BEQ_OPCODE) & zero;
`ifdef IFETCH_BNE_EN
    if (instr_q[31:26] == BNE_OPCODE) branch_c = ~zero;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REQ;
      addr_q  <= '0;
      req_q   <= 1'b0;
      instr_q <= '0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      nsel_q  <= 1'b0;
      imm_q   <= '0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      step_q  <= step_d;
      nsel_q  <= nsel_d;
      imm_q   <= imm_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    req_d   = req_q;
    instr_d = instr_q;
    valid_d = valid_q;
    step_d  = 1'b0;
    nsel_d  = 1'b0;
    imm_d   = imm_q;
    err_d   = 1'b0;
    tcnt_d  = tcnt_q;
    ret_d   = ret_q;
    case (state_q)
      REQ: begin
        addr_d  = pc_in;
        req_d   = 1'b1;
        tcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // An ack on the timeout cycle still wins over the retry
        if (imem_ack) begin
          instr_d = imem_rdata;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = ISSUE;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = REQ;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          step_d  = 1'b1;
          imm_d   = instr_q[15:0];
          nsel_d  = branch_c;
          ret_d   = ret_q + CNT_W'(1);
          state_d = SETTLE;
        end
      end
      SETTLE: state_d = REQ;
      default: state_d = REQ;
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc_step     = step_q;
  assign nPC_sel     = nsel_q;
  assign imm16       = imm_q;
  assign fetch_err   = err_q;
  assign retired     = ret_q;

endmodule
